// File: rtl/servo_pwm.sv
// rtl/servo_pwm.sv - servo PWM generator with angle saturation and per-frame slew limit.
module servo_pwm #(
  parameter int PERIOD    = 2000000,
  parameter int MIN_PULSE = 100000,
  parameter int STEP      = 555,
  parameter int MAX_ANGLE = 180,
  parameter int MAX_SLEW  = 2,
  parameter int RESET_POS = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [19:0] ref_in,
  output logic        pwm,
  output logic [7:0]  pos,
  output logic        busy,
  output logic        frame,
  output logic        sat
);

  typedef enum logic [1:0] {S_OFF, S_HIGH, S_LOW} state_t;

  localparam logic [20:0] LP_LAST  = 21'(PERIOD - 1);
  localparam logic [20:0] LP_MIN   = 21'(MIN_PULSE);
  localparam logic [20:0] LP_STEP  = 21'(STEP);
  localparam logic [7:0]  LP_MAX   = 8'(MAX_ANGLE);
  localparam logic [7:0]  LP_SLEW  = 8'(MAX_SLEW);
  localparam logic [7:0]  LP_RPOS  = 8'(RESET_POS);
  localparam logic [20:0] LP_RWID  = LP_MIN + 21'(LP_RPOS) * LP_STEP;

  state_t      r_state;
  logic [20:0] r_cnt;
  logic [20:0] r_width;
  logic [7:0]  r_pos;
  logic        r_pwm;
  logic        r_busy;
  logic        r_frame;
  logic        r_sat;

  logic        w_over;
  logic [7:0]  w_target;
  logic [7:0]  w_up;
  logic [7:0]  w_dn;
  logic [7:0]  w_pos_new;
  logic [20:0] w_width_new;
  logic        w_frame_evt;

  assign w_over   = (|ref_in[19:8]) || (ref_in[7:0] > LP_MAX);
  assign w_target = w_over ? LP_MAX : ref_in[7:0];
  assign w_up     = w_target - r_pos;
  assign w_dn     = r_pos - w_target;

  // Slew of zero means the servo jumps straight to the target.
  always_comb begin
    w_pos_new = r_pos;
    if (MAX_SLEW == 0)
      w_pos_new = w_target;
    else if (w_target > r_pos)
      w_pos_new = r_pos + ((w_up > LP_SLEW) ? LP_SLEW : w_up);
    else if (w_target < r_pos)
      w_pos_new = r_pos - ((w_dn > LP_SLEW) ? LP_SLEW : w_dn);
  end

  assign w_width_new = LP_MIN + 21'(w_pos_new) * LP_STEP;
  assign w_frame_evt = ((r_state != S_OFF) && (r_cnt == LP_LAST)) ||
                       ((r_state == S_OFF) && en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_width <= LP_RWID;
      r_pos   <= LP_RPOS;
      r_pwm   <= 1'b0;
      r_busy  <= 1'b0;
      r_frame <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_frame <= w_frame_evt;
      if (w_frame_evt) begin
        r_pos   <= w_pos_new;
        r_width <= w_width_new;
        r_sat   <= w_over;
        r_busy  <= (w_pos_new != w_target);
        r_cnt   <= '0;
        r_state <= en ? S_HIGH : S_OFF;
        r_pwm   <= en;
      end else begin
        case (r_state)
          S_HIGH: begin
            r_cnt <= r_cnt + 21'd1;
            if (r_cnt == r_width - 21'd1) begin
              r_state <= S_LOW;
              r_pwm   <= 1'b0;
            end
          end
          S_LOW:   r_cnt <= r_cnt + 21'd1;
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign pwm   = r_pwm;
  assign pos   = r_pos;
  assign busy  = r_busy;
  assign frame = r_frame;
  assign sat   = r_sat;

endmodule

// File: tb/tb_servo_pwm.sv
// tb/tb_servo_pwm.sv - bench driving a no-slew and a slew-limited servo_pwm in lockstep.
module tb_servo_pwm;
  localparam int PER = 1000;
  localparam int MINP = 50;
  localparam int MAXA = 180;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] ref_in;
  logic        pwm_a, busy_a, frame_a, sat_a;
  logic        pwm_b, busy_b, frame_b, sat_b;
  logic [7:0]  pos_a, pos_b;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pos[2];
  int m_sat[2];
  int m_busy[2];
  int m_width[2];
  int m_slew[2] = '{0, 2};

  always #5 clk = ~clk;

  servo_pwm #(.PERIOD(PER), .MIN_PULSE(MINP), .STEP(1), .MAX_ANGLE(MAXA),
              .MAX_SLEW(0), .RESET_POS(90)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .pwm(pwm_a),
    .pos(pos_a), .busy(busy_a), .frame(frame_a), .sat(sat_a));

  servo_pwm #(.PERIOD(PER), .MIN_PULSE(MINP), .STEP(1), .MAX_ANGLE(MAXA),
              .MAX_SLEW(2), .RESET_POS(90)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .pwm(pwm_b),
    .pos(pos_b), .busy(busy_b), .frame(frame_b), .sat(sat_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 90; m_sat[i] = 0; m_busy[i] = 0; m_width[i] = MINP + 90;
    end
  endtask

  // What a frame event does to a servo that samples value r.
  task automatic model_step(input int r);
    int tgt;
    tgt = (r > MAXA) ? MAXA : r;
    for (int i = 0; i < 2; i++) begin
      m_sat[i] = (r > MAXA) ? 1 : 0;
      if (m_slew[i] == 0 || (tgt - m_pos[i] <= m_slew[i] && m_pos[i] - tgt <= m_slew[i]))
        m_pos[i] = tgt;
      else if (tgt > m_pos[i])
        m_pos[i] = m_pos[i] + m_slew[i];
      else
        m_pos[i] = m_pos[i] - m_slew[i];
      m_busy[i]  = (m_pos[i] != tgt) ? 1 : 0;
      m_width[i] = MINP + m_pos[i];
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_pos_a"},  pos_a,  m_pos[0]);
    chk({tag, "_sat_a"},  sat_a,  m_sat[0]);
    chk({tag, "_busy_a"}, busy_a, m_busy[0]);
    chk({tag, "_pos_b"},  pos_b,  m_pos[1]);
    chk({tag, "_sat_b"},  sat_b,  m_sat[1]);
    chk({tag, "_busy_b"}, busy_b, m_busy[1]);
  endtask

  // Called on the negedge where frame is seen; returns on the next such negedge.
  task automatic measure(input int chg_at, input logic [19:0] chg_ref, input int drop_at,
                         output int hi_a, output int hi_b, output int n);
    hi_a = 0; hi_b = 0; n = 0;
    do begin
      if (pwm_a) hi_a++;
      if (pwm_b) hi_b++;
      if (n == chg_at) ref_in = chg_ref;
      if (n == drop_at) en = 1'b0;
      @(negedge clk);
      n++;
    end while (!frame_a && n < 5000);
    chk("frame_len", n, PER);
    chk("frame_sync", frame_b, 1);
  endtask

  task automatic run_frame(input string tag, input logic [19:0] r);
    int ha, hb, n;
    ref_in = r;
    measure(-1, '0, -1, ha, hb, n);
    chk({tag, "_width_a"}, ha, m_width[0]);
    chk({tag, "_width_b"}, hb, m_width[1]);
    model_step(int'(r));
    chk_state(tag);
  endtask

  initial begin
    int ha, hb, n;
    logic [19:0] r;
    int ramp[5] = '{92, 94, 96, 98, 100};

    rst = 1'b1; en = 1'b0; ref_in = 20'd90;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pwm_a", pwm_a, 0);
    chk("rst_frame_a", frame_a, 0);
    chk("rst_pwm_b", pwm_b, 0);
    chk("rst_frame_b", frame_b, 0);
    chk_state("rst");

    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    chk("start_frame", frame_a, 1);
    chk("start_pwm", pwm_a, 1);
    model_step(90);
    chk_state("start");
    run_frame("ref90", 20'd90);
    run_frame("ref90b", 20'd90);

    for (int k = 0; k < 5; k++) begin
      run_frame("slew", 20'd100);
      chk("slew_ramp", pos_b, ramp[k]);
      chk("slew_busy", busy_b, (k < 4) ? 1 : 0);
    end

    run_frame("sat200", 20'h000C8);
    chk("sat200_pos", pos_a, 180);
    run_frame("sat_hi", 20'h10005);
    chk("sat_hi_sat", sat_a, 1);
    run_frame("sat_hold", 20'd0);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) r = 20'($urandom_range(0, 255));
      else                           r = 20'($urandom_range(0, 20'hFFFFF));
      run_frame("rand", r);
    end

    run_frame("pre10", 20'd10);
    measure(30, 20'd170, -1, ha, hb, n);
    chk("midchg_width", ha, 60);
    model_step(170);
    chk_state("midchg");
    run_frame("after170", 20'd170);

    measure(-1, '0, 500, ha, hb, n);
    chk("endrop_width", ha, m_width[0]);
    chk("endrop_pwm", pwm_a, 0);
    model_step(int'(ref_in));
    chk_state("endrop");
    ref_in = 20'd0;
    repeat (5) @(negedge clk);
    chk("off_pwm", pwm_a, 0);
    chk("off_frame", frame_a, 0);
    chk_state("off_hold");
    en = 1'b1;
    @(negedge clk);
    chk("reen_pwm", pwm_a, 1);
    chk("reen_frame", frame_a, 1);
    model_step(0);
    run_frame("reen", 20'd300);

    repeat (20) @(negedge clk);
    chk("mid_pulse_pwm", pwm_a, 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_pwm_a", pwm_a, 0);
    chk("async_pwm_b", pwm_b, 0);
    chk("async_frame", frame_a, 0);
    chk_state("async");
    ref_in = 20'd90;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_frame", frame_a, 1);
    model_step(90);
    run_frame("post_rst", 20'd90);
    chk("post_rst_width", m_width[0], 140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
